mux2_rr_arbiter: RTL and testbench

- Shares one 2:1 datapath mux and its single downstream sink (the register-file write port) between two requesters: requester 0 is the ALU result and requester 1 is the memory load data.
- Arbitrates between the two requesters round-robin.
- Drives the registered mux select and a one-entry output register.
- Counts arbitration conflicts.

---
 rtl/mux2_rr_arbiter.sv | 99 +++++++++
 tb/tb_mux2_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// Define MUX2_ARB_FIXED_PRIO_EN to make requester 1 win every tie.
module mux2_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [TAG_WIDTH-1:0]  req0_tag,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [TAG_WIDTH-1:0]  req1_tag,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  out_ready,
  output logic                  select,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   can_load;
  logic   both;
  logic   gnt0, gnt1;
  logic   xfer0, xfer1, load;

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;
  assign both      = req0_valid && req1_valid;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0_valid && !req1_valid): gnt0 = 1'b1;
      (!req0_valid && req1_valid): gnt1 = 1'b1;
      both: begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
        gnt1 = 1'b1;
`else
        gnt0 = last_grant;
        gnt1 = !last_grant;
`endif
      end
      default: ;
    endcase
  end

  assign req0_ready = can_load && gnt0;
  assign req1_ready = can_load && gnt1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign load       = xfer0 || xfer1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (out_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Payload, select and history only move on an accepted transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_tag    <= '0;
      select     <= 1'b0;
      last_grant <= 1'b1;
    end else if (load) begin
      out_data   <= xfer1 ? req1_data : req0_data;
      out_tag    <= xfer1 ? req1_tag  : req0_tag;
      select     <= xfer1;
      last_grant <= xfer1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= '0;
    else if (both && can_load && (conflict_cnt != {CNT_WIDTH{1'b1}}))
      conflict_cnt <= conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter; a 4-bit-counter copy shares
// the stimulus to exercise counter saturation.
module tb_mux2_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, out_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_tag, req1_tag;
  logic        req0_ready, req1_ready, out_valid, select;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [15:0] conflict_cnt;
  logic        s_r0, s_r1, s_ov, s_sel;
  logic [31:0] s_data;
  logic [4:0]  s_tag;
  logic [3:0]  s_cnt;

  int checks = 0;
  int fails  = 0;
  logic        g;
  logic [31:0] held;

  always #5 clk = ~clk;

  mux2_rr_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_tag(req1_tag), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_tag(out_tag), .out_ready(out_ready),
    .select(select), .conflict_cnt(conflict_cnt)
  );

  mux2_rr_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req0_tag(req0_tag), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req1_tag(req1_tag), .req1_ready(s_r1),
    .out_valid(s_ov), .out_data(s_data),
    .out_tag(s_tag), .out_ready(out_ready),
    .select(s_sel), .conflict_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = 32'hA5A5A5A5; req0_tag = 5'd3;
    req1_valid = 1'b0; req1_data = '0; req1_tag = '0;
    out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_select", select, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_out_data", out_data, 0);

    // Release: req0 alone is granted, loads on the next edge
    reset = 1'b0;
    #1;
    check("rel_r0_ready", req0_ready, 1);
    check("rel_r1_ready", req1_ready, 0);
    step();
    check("rel_out_valid", out_valid, 1);
    check("rel_out_data", out_data, 32'hA5A5A5A5);
    check("rel_out_tag", out_tag, 5'd3);
    check("rel_select", select, 0);
    req0_valid = 1'b0;

    // Only req1, sink ready
    req1_valid = 1'b1; req1_data = 32'h12345678; req1_tag = 5'd7;
    out_ready = 1'b1;
    #1;
    check("r1_only_ready", req1_ready, 1);
    check("r1_only_r0", req0_ready, 0);
    step();
    check("r1_out_valid", out_valid, 1);
    check("r1_out_data", out_data, 32'h12345678);
    check("r1_out_tag", out_tag, 5'd7);
    check("r1_select", select, 1);

    // Four ties, last_grant=1 so round-robin starts with requester 0
    req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_data = 32'h100 + i; req0_tag = 5'd1;
      req1_data = 32'h200 + i; req1_tag = 5'd2;
`ifdef MUX2_ARB_FIXED_PRIO_EN
      g = 1'b1;
`else
      g = (i % 2 == 1);
`endif
      #1;
      check("tie_r0_ready", req0_ready, !g);
      check("tie_r1_ready", req1_ready, g);
      step();
      check("tie_select", select, g);
      check("tie_data", out_data, g ? 32'h200 + i : 32'h100 + i);
    end
    check("tie_cnt4", conflict_cnt, 4);
    check("tie_out_valid", out_valid, 1);

    // Stall with both valid: no readies, stable output, no counting
    held = out_data;
    out_ready = 1'b0;
    req0_data = 32'hAAAA0000; req1_data = 32'hBBBB0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_r0", req0_ready, 0);
      check("stall_r1", req1_ready, 0);
      step();
      check("stall_data", out_data, held);
      check("stall_cnt", conflict_cnt, 4);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
`ifdef MUX2_ARB_FIXED_PRIO_EN
    g = 1'b1;
`else
    g = 1'b0;
`endif
    #1;
    check("unstall_r0", req0_ready, !g);
    check("unstall_r1", req1_ready, g);
    step();
    check("unstall_valid", out_valid, 1);
    check("unstall_select", select, g);
    check("unstall_data", out_data, g ? 32'hBBBB0000 : 32'hAAAA0000);
    check("unstall_cnt", conflict_cnt, 5);

    // Reset mid-stall acts without waiting for a clock edge
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_cnt", conflict_cnt, 0);
    check("arst_select", select, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    req0_data = 32'h0C0C0C0C; req1_data = 32'h1D1D1D1D;
`ifdef MUX2_ARB_FIXED_PRIO_EN
    g = 1'b1;
`else
    g = 1'b0;
`endif
    #1;
    check("post_rst_r0", req0_ready, !g);
    check("post_rst_r1", req1_ready, g);
    step();
    check("post_rst_sel", select, g);
    check("post_rst_data", out_data, g ? 32'h1D1D1D1D : 32'h0C0C0C0C);
    check("post_rst_cnt", conflict_cnt, 1);

    // Saturation: 20 ties from a clean counter
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("sat_start4", s_cnt, 0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", s_cnt, 4'hF);
    check("sat_cnt16", conflict_cnt, 20);
    step();
    check("sat_hold4", s_cnt, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
